zsram_access_controller: RTL and testbench
==========================================

// Module: zsram_access_controller
// PURPOSE
//  Sequences read/write strobes into an array of DEPTH zero-second RAM cell words (WIDTH cells each).
//  Arbitrates between two requesters (index 0 = A, index 1 = B) with 2-way round-robin.
//  Generates a one-hot WriteEdge/ReadEdge per word, holds inputData stable around the strobe,
//  and captures outputData on reads. Sits between the bus-side masters and the cell array.
// PARAMETERS
//  WIDTH          8   data bits per word (cells per word)
//  DEPTH          16  number of words; each word has its own WriteEdge/ReadEdge bit
//  ADDR_W         4   address width, >= clog2(DEPTH)
//  STROBE_CYCLES  2   cycles an edge stays high; legal range 1..15
// PORTS
//  Crystal50Mhz  in   1               single clock, rising edge
//  nReset        in   1               reset, asynchronous, active-low
//  req           in   2               per-requester request, held until the matching gnt bit
//  we            in   2               per-requester 1 = write, 0 = read
//  addr          in   2*ADDR_W        per-requester word address; slice i belongs to requester i
//  wdata         in   2*WIDTH         per-requester write data; slice i belongs to requester i
//  gnt           out  2               one-cycle grant pulse; the request is latched in that cycle
//  done          out  2               one-cycle completion pulse to the granted requester
//  rdata         out  WIDTH           last read result; valid from done onward
//  busy          out  1               high in every state except IDLE
//  WriteEdge     out  DEPTH           per-word write strobe to the cells
//  ReadEdge      out  DEPTH           per-word read strobe to the cells
//  inputData     out  WIDTH           write data to the cells
//  outputData    in   WIDTH           read data from the selected word
// BEHAVIOUR
//  - Reset (async, nReset=0): state IDLE; gnt, done, busy, WriteEdge, ReadEdge, inputData, rdata = 0; lastGnt = 1.
//  - All outputs are registered. At most one bit of WriteEdge|ReadEdge is high in any cycle.
//  - FSM states: IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
//  - IDLE: if any req is high, pick the winner and go to SETUP.
//    Single req: that requester wins. Both: the requester != lastGnt wins, so A wins first after reset.
//  - SETUP (1 cycle):
//    gnt[w] = 1; latch we/addr/wdata of w; lastGnt <= w.
//    inputData = wdata(w) on writes, else 0. All edges still 0.
//  - STROBE (STROBE_CYCLES cycles):
//    write: WriteEdge[addr] = 1; read: ReadEdge[addr] = 1; counter counts down.
//    On a read, rdata <= outputData at the clock edge that leaves STROBE.
//  - RECOVER (1 cycle): all edges 0; inputData still held; done[w] = 1. Next state is always IDLE.
//  - inputData is stable from SETUP through RECOVER and 0 in IDLE. rdata holds until the next read completes.
//  - Latency: gnt in cycle T; edge high cycles T+1..T+STROBE_CYCLES; done in cycle T+STROBE_CYCLES+1.
//    Minimum issue spacing is STROBE_CYCLES+3 cycles.
//  - req dropped before gnt: no transaction, no error. req or data changes after gnt: ignored.
//  - Losing requester keeps req high and is served in the next IDLE.
//  - addr >= DEPTH: no edge is driven, rdata is unchanged, done still pulses, timing is identical.
//  - Reset mid-operation: edges, gnt and done drop asynchronously; the transaction is lost, with no done.
// STRUCTURE
//  - Shared header ZSRAMCtrl.vh holds:
//    state encodings ST_IDLE=2'd0, ST_SETUP=2'd1, ST_STROBE=2'd2, ST_RECOVER=2'd3;
//    requester indices REQ_A=0, REQ_B=1.
//  - One sub-module: zsram_rr_arbiter2 (combinational winner from req[1:0] and lastGnt).
//  - Edge decoder, strobe counter, data latches and FSM stay in this module.
// TESTING
//  - Reset: nReset=0 with all inputs toggling -> every output 0; after release, busy=0.
//  - Write A: addr=3, wdata=8'hA5, STROBE_CYCLES=2 -> gnt[0] in T; WriteEdge=16'h0008 in T+1, T+2;
//    inputData=8'hA5 in T..T+3; done[0] in T+3.
//  - Read B: addr=3, outputData=8'h5A -> ReadEdge=16'h0008 for 2 cycles; rdata=8'h5A when done[1] is high;
//    no WriteEdge at any point.
//  - Contention: req=2'b11 held after reset -> grant order A, B, A; losing req never dropped;
//    gnt pulses 5 cycles apart.
//  - Reset during STROBE -> WriteEdge is 0 before the next clock edge and no done appears;
//    a fresh write after release completes normally.
//  - Out of range, DEPTH=12: addr=13 write -> WriteEdge stays 0; done pulses on schedule; rdata unchanged.

Source files
------------

// File: rtl/zsram_access_controller_pkg.sv
// Shared definitions for the zero-second RAM access controller: FSM state
// encodings, requester indices and the strobe counter width.
`timescale 1ns/1ps
package zsram_access_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Wide enough for STROBE_CYCLES up to 15
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/zsram_rr_arbiter2.sv
// Two-way round-robin arbiter: picks a winner from the request pair and the
// requester granted last. Purely combinational.
`timescale 1ns/1ps
module zsram_rr_arbiter2
    import zsram_access_controller_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_valid,
    output logic       o_winner
);

    // On contention the requester that was not served last wins
    always_comb begin
        o_valid  = |i_req;
        o_winner = REQ_A;
        unique case (i_req)
            2'b01:   o_winner = REQ_A;
            2'b10:   o_winner = REQ_B;
            2'b11:   o_winner = ~i_last_gnt;
            default: o_winner = REQ_A;
        endcase
    end

endmodule

// File: rtl/zsram_access_controller.sv
// Sequences write/read strobes into an array of zero-second RAM words on behalf
// of two arbitrated requesters. Every output is registered.
`timescale 1ns/1ps
module zsram_access_controller
    import zsram_access_controller_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                  Crystal50Mhz,
    input  logic                  nReset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*WIDTH-1:0]    wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic [DEPTH-1:0]      WriteEdge,
    output logic [DEPTH-1:0]      ReadEdge,
    output logic [WIDTH-1:0]      inputData,
    input  logic [WIDTH-1:0]      outputData
);

    state_e              r_state;
    logic                r_last_gnt;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic [WIDTH-1:0]    r_rdata;
    logic                r_busy;
    logic [DEPTH-1:0]    r_wedge;
    logic [DEPTH-1:0]    r_redge;
    logic [WIDTH-1:0]    r_idata;

    logic                w_valid;
    logic                w_winner;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic [WIDTH-1:0]    w_sel_wdata;
    logic                w_in_range;
    logic [DEPTH-1:0]    w_onehot;

    zsram_rr_arbiter2 u_arb (
        .i_req      (req),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_valid),
        .o_winner   (w_winner)
    );

    // Mux the winning requester's command and decode the latched address
    always_comb begin
        w_sel_addr  = w_winner ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
        w_sel_wdata = w_winner ? wdata[WIDTH +: WIDTH] : wdata[0 +: WIDTH];
        w_sel_we    = w_winner ? we[1] : we[0];
        // Out-of-range addresses decode to no edge at all
        w_in_range  = 32'(r_addr) < DEPTH;
        w_onehot    = w_in_range ? (DEPTH'(1) << r_addr) : '0;
    end

    // Transaction FSM with registered strobes, pulses and data latches
    always_ff @(posedge Crystal50Mhz or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= REQ_B;
            r_owner    <= REQ_A;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_wedge    <= '0;
            r_redge    <= '0;
            r_idata    <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state           <= ST_SETUP;
                        r_gnt[w_winner]   <= 1'b1;
                        r_owner           <= w_winner;
                        r_last_gnt        <= w_winner;
                        r_we              <= w_sel_we;
                        r_addr            <= w_sel_addr;
                        r_idata           <= w_sel_we ? w_sel_wdata : '0;
                        r_busy            <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= CNT_W'(STROBE_CYCLES - 1);
                    if (r_we) begin
                        r_wedge <= w_onehot;
                    end else begin
                        r_redge <= w_onehot;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state        <= ST_RECOVER;
                        r_wedge        <= '0;
                        r_redge        <= '0;
                        r_done[r_owner] <= 1'b1;
                        // Sample the cell output at the edge that ends the read strobe
                        if (!r_we && w_in_range) begin
                            r_rdata <= outputData;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_idata <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign WriteEdge = r_wedge;
    assign ReadEdge  = r_redge;
    assign inputData = r_idata;

endmodule

// File: tb/tb_zsram_access_controller.sv
// Directed bench for zsram_access_controller with a completion scoreboard.
// A second instance with DEPTH=12 shares the inputs to exercise out-of-range addresses.
`timescale 1ns/1ps
module tb_zsram_access_controller;

    localparam int S = 2;

    typedef struct {
        int         idx;
        logic [7:0] rd;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        nReset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  outputData;

    logic [1:0]  gnt, done;
    logic [7:0]  rdata, inputData;
    logic        busy;
    logic [15:0] WriteEdge, ReadEdge;

    logic [1:0]  gnt12, done12;
    logic [7:0]  rdata12, inputData12;
    logic        busy12;
    logic [11:0] WriteEdge12, ReadEdge12;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  exp_rd = 8'h00;
    logic [7:0]  exp_rd12 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zsram_access_controller #(
        .WIDTH(8), .DEPTH(16), .ADDR_W(4), .STROBE_CYCLES(S)
    ) dut (
        .Crystal50Mhz (clk),
        .nReset       (nReset),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .busy         (busy),
        .WriteEdge    (WriteEdge),
        .ReadEdge     (ReadEdge),
        .inputData    (inputData),
        .outputData   (outputData)
    );

    zsram_access_controller #(
        .WIDTH(8), .DEPTH(12), .ADDR_W(4), .STROBE_CYCLES(S)
    ) dut12 (
        .Crystal50Mhz (clk),
        .nReset       (nReset),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt12),
        .done         (done12),
        .rdata        (rdata12),
        .busy         (busy12),
        .WriteEdge    (WriteEdge12),
        .ReadEdge     (ReadEdge12),
        .inputData    (inputData12),
        .outputData   (outputData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oh16(input logic [3:0] a);
        logic [15:0] one = 16'd1;
        return one << a;
    endfunction

    function automatic logic [11:0] oh12(input logic [3:0] a);
        logic [11:0] one = 12'd1;
        return (a < 4'd12) ? (one << a) : 12'd0;
    endfunction

    // Completion scoreboard: every done must match the oldest granted transaction
    always @(negedge clk) begin
        if (nReset) begin
            chk("edge_onehot0", 32'($onehot0(WriteEdge | ReadEdge)), 32'd1);
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_mask", 32'(done), 32'(2'b01 << mon_e.idx));
                    chk("done_rdata", 32'(rdata), 32'(mon_e.rd));
                    chk("done_latency", 32'(cyc - mon_e.t), 32'(S + 1));
                end
            end
        end
    end

    // One complete transaction from an idle controller, checked cycle by cycle
    task automatic run_txn(input int idx, input bit w, input logic [3:0] a,
                           input logic [7:0] d, input logic [7:0] od);
        bit got = 0;
        logic [7:0] exp_id;
        exp_id = w ? d : 8'h00;
        outputData = od;
        we[idx] = w;
        addr[idx*4 +: 4] = a;
        wdata[idx*8 +: 8] = d;
        req[idx] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (gnt != 2'b00) got = 1;
        end
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            req[idx] = 1'b0;
            return;
        end
        if (!w) exp_rd = od;
        if (!w && a < 4'd12) exp_rd12 = od;
        sb.push_back('{idx, exp_rd, cyc});
        req[idx] = 1'b0;
        chk("txn_gnt", 32'(gnt), 32'(2'b01 << idx));
        chk("txn_setup_idata", 32'(inputData), 32'(exp_id));
        chk("txn_setup_edges", 32'(WriteEdge | ReadEdge), 32'd0);
        chk("txn_setup_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= S; k++) begin
            step();
            chk("txn_wedge", 32'(WriteEdge), 32'(w ? oh16(a) : 16'd0));
            chk("txn_redge", 32'(ReadEdge), 32'(w ? 16'd0 : oh16(a)));
            chk("txn_wedge12", 32'(WriteEdge12), 32'(w ? oh12(a) : 12'd0));
            chk("txn_redge12", 32'(ReadEdge12), 32'(w ? 12'd0 : oh12(a)));
            chk("txn_strobe_idata", 32'(inputData), 32'(exp_id));
            chk("txn_strobe_done", 32'(done), 32'd0);
        end
        step();
        chk("txn_rec_edges", 32'(WriteEdge | ReadEdge), 32'd0);
        chk("txn_rec_idata", 32'(inputData), 32'(exp_id));
        chk("txn_done12", 32'(done12), 32'(2'b01 << idx));
        chk("txn_rdata12", 32'(rdata12), 32'(exp_rd12));
        chk("txn_rec_busy", 32'(busy), 32'd1);
        step();
        chk("txn_idle_busy", 32'(busy), 32'd0);
        chk("txn_idle_idata", 32'(inputData), 32'd0);
        chk("txn_idle_done", 32'(done), 32'd0);
    endtask

    task automatic hard_reset();
        nReset = 1'b0;
        sb.delete();
        exp_rd = 8'h00;
        exp_rd12 = 8'h00;
        step();
        step();
        @(negedge clk);
        nReset = 1'b1;
        step();
    endtask

    initial begin
        int tprev;
        bit got;
        nReset = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; outputData = '0;

        // Reset with inputs toggling: all outputs held at zero
        for (int i = 0; i < 4; i++) begin
            step();
            req = 2'($urandom); we = 2'($urandom); addr = 8'($urandom);
            wdata = 16'($urandom); outputData = 8'($urandom);
            #2;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_edges", 32'(WriteEdge | ReadEdge), 32'd0);
            chk("rst_idata", 32'(inputData), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
        end
        req = '0;
        @(negedge clk);
        nReset = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'd0);

        // Write A then read B at word 3
        run_txn(0, 1'b1, 4'd3, 8'hA5, 8'h00);
        run_txn(1, 1'b0, 4'd3, 8'h00, 8'h5A);
        chk("read_b_rdata_held", 32'(rdata), 32'h5A);

        // Contention from reset: A, B, A with 5-cycle spacing
        hard_reset();
        we = 2'b11; addr = {4'd2, 4'd1}; wdata = {8'hBB, 8'hAA};
        req = 2'b11;
        tprev = 0;
        for (int g = 0; g < 3; g++) begin
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                if (gnt != 2'b00) got = 1;
            end
            if (!got) begin
                chk("cont_gnt_timeout", 32'd0, 32'd1);
            end else begin
                chk("cont_gnt", 32'(gnt), (g == 1) ? 32'd2 : 32'd1);
                chk("cont_idata", 32'(inputData), (g == 1) ? 32'hBB : 32'hAA);
                if (g > 0) chk("cont_spacing", 32'(cyc - tprev), 32'd5);
                sb.push_back('{(g == 1) ? 1 : 0, exp_rd, cyc});
                tprev = cyc;
            end
        end
        req = '0;
        repeat (5) step();

        // Reset during STROBE: edge drops before the next clock, transaction lost
        we[0] = 1'b1; addr[3:0] = 4'd5; wdata[7:0] = 8'h3C; req[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (gnt != 2'b00) got = 1;
        end
        if (!got) chk("mid_gnt_timeout", 32'd0, 32'd1);
        req[0] = 1'b0;
        step();
        chk("mid_edge_before", 32'(WriteEdge), 32'h0020);
        #2;
        nReset = 1'b0;
        sb.delete();
        exp_rd = 8'h00;
        exp_rd12 = 8'h00;
        #1;
        chk("mid_edge_async", 32'(WriteEdge), 32'd0);
        chk("mid_busy_async", 32'(busy), 32'd0);
        chk("mid_done_async", 32'(done), 32'd0);
        step();
        @(negedge clk);
        nReset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_no_done", 32'(done), 32'd0);
        end
        run_txn(0, 1'b1, 4'd7, 8'h96, 8'h00);

        // Out of range on the DEPTH=12 instance: no edges, done on time, rdata held
        run_txn(1, 1'b0, 4'd4, 8'h00, 8'h77);
        run_txn(0, 1'b1, 4'd13, 8'h11, 8'h00);
        run_txn(0, 1'b0, 4'd13, 8'h00, 8'hC3);
        chk("oor_rdata12_held", 32'(rdata12), 32'h77);
        chk("oor_rdata16", 32'(rdata), 32'hC3);

        repeat (3) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
